flap_game_ctrl: RTL and testbench

Top-level game sequencer for the flappy-bird datapath. Generates the per-frame enable to the bird and pipe blocks. Converts the player button into one-frame jump requests, drives the bird's play/hold `state` input and its `fall_accel` difficulty level. Detects death, keeps score and high score, and runs the IDLE/PLAY/DYING/OVER game state machine.

---
 rtl/flap_pkg.sv | 28 ++
 rtl/frame_tick_gen.sv | 26 ++
 rtl/flap_game_ctrl.sv | 126 ++++++++++++
 tb/tb_flap_game_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/flap_pkg.sv
// Shared types and constants for the flappy-bird game sequencer.
package flap_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        DYING = 2'd2,
        OVER  = 2'd3
    } game_state_t;

    localparam int unsigned       GROUND_Y_DEF   = 440;
    localparam int unsigned       SCORE_W        = 8;
    localparam logic [SCORE_W-1:0] SCORE_MAX     = '1;
    localparam logic [1:0]        FALL_ACCEL_MIN = 2'd1;
    localparam logic [1:0]        FALL_ACCEL_MAX = 2'd3;

    // 1 + min(score / step, 2), done with compares instead of a divider
    function automatic logic [1:0] accel_level(input logic [SCORE_W-1:0] s,
                                               input int unsigned        step);
        if (32'(s) >= 2 * step)
            return FALL_ACCEL_MAX;
        else if (32'(s) >= step)
            return FALL_ACCEL_MIN + 2'd1;
        else
            return FALL_ACCEL_MIN;
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Free-running frame divider: tick is high for one cycle every TICK_DIV clocks.
module frame_tick_gen #(
    parameter int unsigned TICK_DIV = 1666667
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned   CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst)
            count <= '0;
        else if (count == LAST)
            count <= '0;
        else
            count <= count + CW'(1);
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/flap_game_ctrl.sv
// Game sequencer: frame strobes, jump requests, death detection, scoring and
// the IDLE/PLAY/DYING/OVER state machine.
module flap_game_ctrl
    import flap_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 1666667,
    parameter int unsigned GROUND_Y   = GROUND_Y_DEF,
    parameter int unsigned ACCEL_STEP = 8,
    parameter int unsigned OVER_HOLD  = 60
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_flap,
    input  logic [9:0]         bird_y,
    input  logic               collision,
    input  logic               score_pulse,
    output logic               bird_en,
    output logic               bird_jump,
    output logic               play,
    output logic [1:0]         fall_accel,
    output logic               pipe_en,
    output logic [1:0]         game_state,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] hi_score,
    output logic               game_over
);

    localparam int unsigned   HW        = (OVER_HOLD > 0) ? $clog2(OVER_HOLD + 1) : 1;
    localparam logic [HW-1:0] HOLD_INIT = HW'(OVER_HOLD);

    game_state_t        state, state_nxt;
    logic               tick;
    logic               btn_q;
    logic               rise;
    logic               ground;
    logic               flap_pending, pending_nxt;
    logic [HW-1:0]      hold_cnt;
    logic [SCORE_W-1:0] score_nxt;

    frame_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    assign rise       = btn_flap & ~btn_q;
    assign ground     = (32'(bird_y) >= GROUND_Y);
    assign game_state = state;

    always_comb begin
        state_nxt   = state;
        pending_nxt = flap_pending;
        score_nxt   = score;
        unique case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt   = PLAY;
                    pending_nxt = 1'b1;
                    score_nxt   = '0;
                end
            end
            PLAY: begin
                // a rise on the consuming tick wins, so that flap is not lost
                if (tick)
                    pending_nxt = 1'b0;
                if (rise)
                    pending_nxt = 1'b1;
                if (collision || ground)
                    state_nxt = DYING;
                else if (score_pulse && score != SCORE_MAX)
                    score_nxt = score + SCORE_W'(1);
            end
            DYING: begin
                pending_nxt = 1'b0;
                if (ground)
                    state_nxt = OVER;
            end
            OVER: begin
                if (hold_cnt == '0 && rise)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            btn_q        <= 1'b0;
            flap_pending <= 1'b0;
            hold_cnt     <= '0;
            score        <= '0;
            hi_score     <= '0;
            bird_en      <= 1'b0;
            bird_jump    <= 1'b0;
            pipe_en      <= 1'b0;
            play         <= 1'b0;
            game_over    <= 1'b0;
            fall_accel   <= FALL_ACCEL_MIN;
        end else begin
            state        <= state_nxt;
            btn_q        <= btn_flap;
            flap_pending <= pending_nxt;
            score        <= score_nxt;

            if (state == DYING && state_nxt == OVER) begin
                hold_cnt <= HOLD_INIT;
                if (score > hi_score)
                    hi_score <= score;
            end else if (state == OVER && tick && hold_cnt != '0) begin
                hold_cnt <= hold_cnt - HW'(1);
            end

            // strobes follow the current state; levels track the next state
            bird_en    <= tick && (state == PLAY || state == DYING);
            pipe_en    <= tick && (state == PLAY);
            bird_jump  <= tick && (state == PLAY) && flap_pending;
            play       <= (state_nxt == PLAY) || (state_nxt == DYING);
            game_over  <= (state_nxt == OVER);
            fall_accel <= accel_level(score_nxt, ACCEL_STEP);
        end
    end

endmodule

// File: tb/tb_flap_game_ctrl.sv
// Directed bench for flap_game_ctrl with a short frame (TICK_DIV=4) and hold (OVER_HOLD=3).
module tb_flap_game_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_flap;
    logic [9:0] bird_y;
    logic       collision;
    logic       score_pulse;
    logic       bird_en;
    logic       bird_jump;
    logic       play;
    logic [1:0] fall_accel;
    logic       pipe_en;
    logic [1:0] game_state;
    logic [7:0] score;
    logic [7:0] hi_score;
    logic       game_over;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    flap_game_ctrl #(
        .TICK_DIV  (4),
        .GROUND_Y  (440),
        .ACCEL_STEP(8),
        .OVER_HOLD (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_flap   (btn_flap),
        .bird_y     (bird_y),
        .collision  (collision),
        .score_pulse(score_pulse),
        .bird_en    (bird_en),
        .bird_jump  (bird_jump),
        .play       (play),
        .fall_accel (fall_accel),
        .pipe_en    (pipe_en),
        .game_state (game_state),
        .score      (score),
        .hi_score   (hi_score),
        .game_over  (game_over)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // advance to the next negedge at which bird_en is high, bounded
    task automatic wait_frame(input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bird_en) begin
                found = 1'b1;
                break;
            end
        end
        check_eq({tag, "_frame_seen"}, 32'(found), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_state"},      32'(game_state), 0);
        check_eq({tag, "_bird_en"},    32'(bird_en),    0);
        check_eq({tag, "_bird_jump"},  32'(bird_jump),  0);
        check_eq({tag, "_play"},       32'(play),       0);
        check_eq({tag, "_pipe_en"},    32'(pipe_en),    0);
        check_eq({tag, "_fall_accel"}, 32'(fall_accel), 1);
        check_eq({tag, "_score"},      32'(score),      0);
        check_eq({tag, "_hi_score"},   32'(hi_score),   0);
        check_eq({tag, "_game_over"},  32'(game_over),  0);
    endtask

    initial begin
        int unsigned exp_acc;
        int          dying_frames;

        rst         = 1'b0;
        btn_flap    = 1'b0;
        bird_y      = 10'd200;
        collision   = 1'b0;
        score_pulse = 1'b0;

        // 1: reset, then idle for 20 cycles
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_eq("idle_state",  32'(game_state), 0);
            check_eq("idle_play",   32'(play),       0);
            check_eq("idle_accel",  32'(fall_accel), 1);
            check_eq("idle_bird_en", 32'(bird_en),   0);
        end

        // 2: one-cycle press starts the game; first frame jumps
        btn_flap = 1'b1;
        @(negedge clk);
        btn_flap = 1'b0;
        check_eq("start_state", 32'(game_state), 1);
        check_eq("start_play",  32'(play),       1);
        wait_frame("first");
        check_eq("first_jump", 32'(bird_jump), 1);
        check_eq("first_pipe", 32'(pipe_en),   1);
        for (int f = 0; f < 2; f++) begin
            wait_frame("next");
            check_eq("next_jump", 32'(bird_jump), 0);
            check_eq("next_pipe", 32'(pipe_en),   1);
        end

        // 3: 17 consecutive score pulses, then a pulse with collision
        score_pulse = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            @(negedge clk);
            exp_acc = (i >= 16) ? 3 : (i >= 8) ? 2 : 1;
            check_eq("score_count", 32'(score),      32'(i));
            check_eq("score_accel", 32'(fall_accel), exp_acc);
        end
        collision = 1'b1;
        @(negedge clk);
        check_eq("collide_state", 32'(game_state), 2);
        check_eq("collide_score", 32'(score),      17);
        score_pulse = 1'b0;
        collision   = 1'b0;

        // 4: dying ignores flaps and freezes pipes, bird still falls
        btn_flap     = 1'b1;
        bird_y       = 10'd300;
        dying_frames = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 2)
                btn_flap = 1'b0;
            check_eq("dying_jump", 32'(bird_jump), 0);
            check_eq("dying_pipe", 32'(pipe_en),   0);
            if (bird_en)
                dying_frames++;
        end
        check_eq("dying_fall",  32'(dying_frames > 0), 1);
        check_eq("dying_state", 32'(game_state),       2);
        bird_y = 10'd440;
        @(negedge clk);
        check_eq("over_state",    32'(game_state), 3);
        check_eq("over_flag",     32'(game_over),  1);
        check_eq("over_play",     32'(play),       0);
        check_eq("over_hi_score", 32'(hi_score),   17);
        check_eq("over_score",    32'(score),      17);

        // 5: early press ignored, later press returns to idle, restart
        btn_flap = 1'b1;
        @(negedge clk);
        btn_flap = 1'b0;
        check_eq("hold_ignore", 32'(game_state), 3);
        repeat (16) @(negedge clk);
        bird_y   = 10'd200;
        btn_flap = 1'b1;
        @(negedge clk);
        btn_flap = 1'b0;
        check_eq("release_state", 32'(game_state), 0);
        check_eq("release_play",  32'(play),       0);
        check_eq("release_over",  32'(game_over),  0);
        check_eq("release_score", 32'(score),      17);
        @(negedge clk);
        btn_flap = 1'b1;
        @(negedge clk);
        btn_flap = 1'b0;
        check_eq("restart_state", 32'(game_state), 1);
        check_eq("restart_score", 32'(score),      0);
        check_eq("restart_hi",    32'(hi_score),   17);
        check_eq("restart_accel", 32'(fall_accel), 1);

        // 6: reset mid-play
        score_pulse = 1'b1;
        repeat (5) @(negedge clk);
        score_pulse = 1'b0;
        check_eq("pre_reset_score", 32'(score), 5);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        rst = 1'b1;
        @(negedge clk);
        check_eq("post_reset_state", 32'(game_state), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
